// File: rtl/interval_counter_pkg.sv
// Shared encodings for the interval counter: command codes, channel state
// values and the channel-select width helper.
package interval_counter_pkg;

    localparam logic [1:0] CMD_LOAD       = 2'd0;
    localparam logic [1:0] CMD_SET_PERIOD = 2'd1;
    localparam logic [1:0] CMD_START      = 2'd2;
    localparam logic [1:0] CMD_STOP       = 2'd3;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Channel-select width; at least one bit even for a single channel.
    function automatic int unsigned ch_sel_w(input int unsigned n);
        return (n > 1) ? unsigned'($clog2(n)) : 1;
    endfunction

endpackage

// File: rtl/interval_channel.sv
// One prescaled counter channel: IDLE/RUN state, count, period and prescaler,
// with registered tick, running and sticky overflow outputs.
module interval_channel
    import interval_counter_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned PW         = 8,
    parameter int unsigned DEF_PERIOD = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld,
    input  logic             set_per,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             running,
    output logic             ovf
);

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [PW-1:0]    per_q, per_d;
    logic [PW-1:0]    pre_q, pre_d;
    logic             tick_q, tick_d;
    logic             ovf_q, ovf_d;
    logic [PW-1:0]    pe_m1;
    logic             due;

    // A zero period behaves as a period of one.
    assign pe_m1 = (per_q == '0) ? '0 : per_q - PW'(1);
    assign due   = (state_q == ST_RUN) && (pre_q == pe_m1);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        per_d   = per_q;
        pre_d   = pre_q;
        tick_d  = 1'b0;
        ovf_d   = ovf_q & ~ovf_clr;

        if (state_q == ST_RUN) begin
            if (due) begin
                pre_d   = '0;
                count_d = count_q + WIDTH'(1);
                tick_d  = 1'b1;
                if (&count_q) begin
                    ovf_d = 1'b1;
                end
            end else begin
                pre_d = pre_q + PW'(1);
            end
        end

        // Commands override the free-running update on the same edge.
        if (stop) begin
            state_d = ST_IDLE;
            count_d = count_q;
            pre_d   = pre_q;
            tick_d  = 1'b0;
            ovf_d   = ovf_q & ~ovf_clr;
        end else if (start) begin
            if (state_q == ST_IDLE) begin
                state_d = ST_RUN;
                pre_d   = '0;
            end
        end else if (ld) begin
            count_d = wr_data;
            pre_d   = '0;
            tick_d  = 1'b0;
            ovf_d   = ovf_q & ~ovf_clr;
        end else if (set_per) begin
            per_d = wr_data[PW-1:0];
            pre_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            per_q   <= PW'(DEF_PERIOD);
            pre_q   <= '0;
            tick_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            per_q   <= per_d;
            pre_q   <= pre_d;
            tick_q  <= tick_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count   = count_q;
    assign tick    = tick_q;
    assign running = (state_q == ST_RUN);
    assign ovf     = ovf_q;

endmodule

// File: rtl/interval_counter.sv
// Multi-channel interval counter: decodes the shared command port into
// per-channel strobes and packs the channel outputs.
module interval_counter
    import interval_counter_pkg::*;
#(
    parameter int unsigned CHANNELS   = 4,
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned PW         = 8,
    parameter int unsigned DEF_PERIOD = 7
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                wr_en,
    input  logic [ch_sel_w(CHANNELS)-1:0]       wr_ch,
    input  logic [1:0]                          wr_cmd,
    input  logic [WIDTH-1:0]                    wr_data,
    input  logic [CHANNELS-1:0]                 ovf_clr,
    output logic [CHANNELS*WIDTH-1:0]           count,
    output logic [CHANNELS-1:0]                 tick,
    output logic [CHANNELS-1:0]                 running,
    output logic [CHANNELS-1:0]                 ovf
);

    localparam int unsigned CW = ch_sel_w(CHANNELS);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic sel;

        // Out-of-range channel numbers never match any instance.
        assign sel = wr_en && (wr_ch == CW'(i));

        interval_channel #(
            .WIDTH      (WIDTH),
            .PW         (PW),
            .DEF_PERIOD (DEF_PERIOD)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .ld      (sel && (wr_cmd == CMD_LOAD)),
            .set_per (sel && (wr_cmd == CMD_SET_PERIOD)),
            .start   (sel && (wr_cmd == CMD_START)),
            .stop    (sel && (wr_cmd == CMD_STOP)),
            .wr_data (wr_data),
            .ovf_clr (ovf_clr[i]),
            .count   (count[i*WIDTH +: WIDTH]),
            .tick    (tick[i]),
            .running (running[i]),
            .ovf     (ovf[i])
        );
    end

endmodule
